// File: rtl/seq_div_16by8.sv
// Iterative restoring divider, 16-bit dividend / 8-bit divisor, one quotient bit per clock.
// A zero divisor bypasses iteration and completes on the accept edge with dbz set.
module seq_div_16by8 (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] dividend,
    input  logic [7:0]  divisor,
    output logic        busy,
    output logic        done,
    output logic [15:0] quotient,
    output logic [7:0]  remainder,
    output logic        dbz
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t      state, state_nx;
    logic [15:0] q;
    logic [7:0]  r;
    logic [7:0]  d;
    logic [3:0]  cnt;
    logic        accept;
    logic        last;
    logic [8:0]  t;
    logic [8:0]  diff;
    logic        ge;
    logic [7:0]  r_nx;
    logic [15:0] q_nx;

    assign accept = start && (state != S_RUN);
    assign last   = (cnt == 4'hF);

    // One restoring step: shift the next dividend bit into the partial remainder.
    assign t    = {r, q[15]};
    assign diff = t - {1'b0, d};
    assign ge   = (t >= {1'b0, d});
    assign r_nx = ge ? diff[7:0] : t[7:0];
    assign q_nx = {q[14:0], ge};

    always_comb begin
        state_nx = state;
        if (accept) begin
            state_nx = (divisor == 8'd0) ? S_DONE : S_RUN;
        end else begin
            case (state)
                S_RUN:   if (last) state_nx = S_DONE;
                S_DONE:  state_nx = S_IDLE;
                default: state_nx = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            q         <= '0;
            r         <= '0;
            d         <= '0;
            cnt       <= '0;
            quotient  <= '0;
            remainder <= '0;
            dbz       <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                if (divisor != 8'd0) begin
                    q   <= dividend;
                    r   <= '0;
                    d   <= divisor;
                    cnt <= '0;
                end else begin
                    quotient  <= 16'hFFFF;
                    remainder <= dividend[7:0];
                    dbz       <= 1'b1;
                end
            end else if (state == S_RUN) begin
                q   <= q_nx;
                r   <= r_nx;
                cnt <= cnt + 4'd1;
                if (last) begin
                    quotient  <= q_nx;
                    remainder <= r_nx;
                    dbz       <= 1'b0;
                end
            end
        end
    end

    assign busy = (state == S_RUN);
    assign done = (state == S_DONE);
endmodule

// File: doc/seq_div_16by8.md
# seq_div_16by8

Iterative restoring divider: 16-bit unsigned dividend by 8-bit unsigned divisor, producing a 16-bit quotient and an 8-bit remainder. It is the inverse of the 8x8 Dadda multiplier datapath: a 16-bit product divided by one of its 8-bit factors returns the other factor. It retires one quotient bit per clock behind a start/busy/done handshake. The block sits beside the multiplier in the arithmetic unit.

## Interface
- No parameters. Widths are fixed: dividend 16 bits, divisor 8 bits.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request a division; sampled on the rising edge.
- `dividend`  in  16  numerator; sampled only on the edge that accepts `start`.
- `divisor`  in  8  denominator; sampled only on the edge that accepts `start`.
- `busy`  out  1  high while iterating (state RUN).
- `done`  out  1  one-cycle pulse; result valid.
- `quotient`  out  16  registered result.
- `remainder`  out  8  registered result.
- `dbz`  out  1  divide-by-zero flag for the last result.

## Operation
- FSM states and transitions:
  - IDLE: waits for `start`.
  - RUN: 16 iterations, tracked by a 4-bit counter.
  - DONE: lasts one cycle, then returns to IDLE.
- `start` is accepted only in IDLE or DONE.
  - `start` is ignored in RUN; operands are not re-sampled.
- On acceptance with `divisor != 0`:
  - Load the working quotient/shift register Q[15:0] with `dividend`.
  - Clear the partial remainder R[7:0] and the counter.
  - Capture `divisor` in register D.
  - Go to RUN.
- RUN iteration, once per clock:
  - T[8:0] = {R, Q[15]}.
  - If T >= {1'b0, D}: R <= T − D (the result always fits 8 bits); qbit = 1.
  - Else: R <= T[7:0]; qbit = 0.
  - Q <= {Q[14:0], qbit}.
  - The counter increments. After the 16th iteration (counter was 15): copy Q to `quotient`, R to `remainder`, clear `dbz`, go to DONE.
- On acceptance with `divisor == 0`:
  - Skip RUN and go directly to DONE.
  - `quotient` = 16'hFFFF, `remainder` = `dividend[7:0]`, `dbz` = 1.
- `quotient`, `remainder` and `dbz` change only on completion. They hold their values until the next completion or reset.
- `busy` = (state == RUN). `done` = (state == DONE). Both are registered state decodes and have no combinational path from the inputs.
- Reset (any state, including mid-RUN):
  - State goes to IDLE; the in-flight operation is abandoned with no `done`.
  - Outputs: `busy` = 0, `done` = 0, `quotient` = 0, `remainder` = 0, `dbz` = 0.
  - Internal Q, R, D and the counter are cleared.
  - `rst` takes priority over `start` on the same edge.

## Timing
- Let the edge that accepts `start` be edge k.
- Normal divisor:
  - `busy` = 1 from after edge k through edge k+16.
  - `done` = 1, with results valid, for exactly one cycle after edge k+16.
  - Latency is 16 clocks, start-accept to `done`.
- Zero divisor: `done` = 1, with results valid, for exactly one cycle after edge k. Latency is 1 clock.
- Back-to-back operation:
  - `start` held high in the DONE cycle is accepted on the next edge.
  - `busy` rises on that same edge; there is no IDLE gap.
  - Throughput is one division per 17 clocks.
- `start` held high continuously re-launches a new division every time the block reaches DONE.
- In the cycle after an accepted `start`, the inputs may change freely.

## Test plan
- 100 / 7: start at edge k → `busy` high for 16 cycles; `done` after edge k+16; `quotient` = 14, `remainder` = 2, `dbz` = 0.
- Corner operands:
  - 16'hFFFF / 1 → `quotient` = 16'hFFFF, `remainder` = 0.
  - 16'hFFFF / 8'hFF → `quotient` = 257, `remainder` = 0.
  - 5 / 200 → `quotient` = 0, `remainder` = 5.
- 16'h1234 / 0 → `done` one cycle after accept; `quotient` = 16'hFFFF, `remainder` = 8'h34, `dbz` = 1, `busy` never high. A following 10 / 3 → 3 rem 1 with `dbz` cleared.
- `start` pulsed with new operands at cycle 5 of RUN → ignored; the original result is delivered on schedule. `start` asserted in the DONE cycle → new division begins with no gap; the second `done` comes 17 clocks after the first.
- `rst` asserted at cycle 8 of RUN, together with `start` → next cycle shows `busy` = 0, `done` = 0, all outputs 0; no `done` ever appears for the aborted operation. A subsequent division completes correctly.
- Random 8-bit a, b (b != 0): divide the multiplier product a*b by b → `quotient` = a, `remainder` = 0. Also run 2000 random dividend/divisor pairs against a reference model.
